// File: rtl/col_parity_pkg.sv
// Shared types and helpers for the column-parity / theta engine.
package col_parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  localparam logic MODE_PARITY = 1'b0;
  localparam logic MODE_THETA  = 1'b1;

  // Upper bounds for the generic parity helper; callers zero-extend into them.
  localparam int MAX_ROWS = 16;
  localparam int MAX_COLS = 16;

  // Column parity of a rows x cols slice where bit y*cols+x = A[x][y].
  function automatic logic [MAX_COLS-1:0] col_parity(
    input logic [MAX_ROWS*MAX_COLS-1:0] line,
    input int                           rows,
    input int                           cols
  );
    logic [MAX_COLS-1:0] p;
    p = '0;
    for (int y = 0; y < MAX_ROWS; y++) begin
      for (int x = 0; x < MAX_COLS; x++) begin
        if (y < rows && x < cols) begin
          p[x] = p[x] ^ line[y*cols+x];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/col_parity_slice.sv
// Combinational slice datapath: column parity of one slice plus theta mixing
// against the current and previous-slice parities.
module col_parity_slice
  import col_parity_pkg::*;
#(
  parameter int ROWS = 5,
  parameter int COLS = 5
) (
  input  logic [ROWS*COLS-1:0] line,
  input  logic [COLS-1:0]      prev_par,
  input  logic                 use_ext,
  input  logic [COLS-1:0]      ext_par,
  output logic [COLS-1:0]      par,
  output logic [ROWS*COLS-1:0] theta
);

  logic [MAX_ROWS*MAX_COLS-1:0] line_ext;
  logic [MAX_COLS-1:0]          par_ext;
  logic [COLS-1:0]              cur_par;
  logic                         unused_par_ext;

  always_comb begin
    line_ext                  = '0;
    line_ext[ROWS*COLS-1:0]   = line;
  end

  assign par_ext        = col_parity(line_ext, ROWS, COLS);
  assign par            = par_ext[COLS-1:0];
  assign unused_par_ext = ^par_ext;

  // The held slice-0 parity replaces the freshly computed one when flushing.
  assign cur_par = use_ext ? ext_par : par;

  for (genvar y = 0; y < ROWS; y++) begin : g_row
    for (genvar x = 0; x < COLS; x++) begin : g_col
      assign theta[y*COLS+x] = line[y*COLS+x]
                             ^ cur_par[(x+COLS-1)%COLS]
                             ^ prev_par[(x+1)%COLS];
    end
  end

endmodule

// File: rtl/col_parity_engine.sv
// Streaming column-parity / theta engine: one slice per handshake, parity-only
// or theta mode with slice 0 held back and emitted last.
module col_parity_engine
  import col_parity_pkg::*;
#(
  parameter int ROWS  = 5,
  parameter int COLS  = 5,
  parameter int DEPTH = 64,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [ROWS*COLS-1:0] line_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [ROWS*COLS-1:0] write_value,
  output logic [CW-2:0]        write_index,
  output logic                 write_enable,
  input  logic                 write_ready,
  output logic [CW-1:0]        cnt_value,
  output logic                 donee,
  output logic [1:0]           state_dbg
);

  localparam int            W    = ROWS * COLS;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  state_t          state;
  logic            mode_q;
  logic [W-1:0]    held_line;
  logic [COLS-1:0] held_par;
  logic [COLS-1:0] prev_par;

  logic            in_flush;
  logic            slot0;
  logic            accept;
  logic            emit;
  logic            flush_load;
  logic            drain;
  logic            load;
  logic [W-1:0]    slice_line;
  logic [COLS-1:0] slice_par;
  logic [W-1:0]    slice_theta;
  logic [W-1:0]    par_line;

  assign in_flush   = (state == FLUSH);
  assign slice_line = in_flush ? held_line : line_in;

  col_parity_slice #(
    .ROWS(ROWS),
    .COLS(COLS)
  ) u_slice (
    .line    (slice_line),
    .prev_par(prev_par),
    .use_ext (in_flush),
    .ext_par (held_par),
    .par     (slice_par),
    .theta   (slice_theta)
  );

  always_comb begin
    par_line           = '0;
    par_line[COLS-1:0] = slice_par;
  end

  // Handshakes: a beat moves on a rising edge where valid && ready. The output
  // register holds write_value/write_index stable while write_enable is high
  // and write_ready is low. Theta slice 0 bypasses the output register.
  assign slot0      = (mode_q == MODE_THETA) && (cnt_value == '0);
  assign in_ready   = (state == STREAM) && (!write_enable || write_ready || slot0);
  assign accept     = in_valid && in_ready;
  assign emit       = accept && !slot0;
  assign drain      = write_enable && write_ready;
  assign flush_load = in_flush && (!write_enable || write_ready);
  assign load       = emit || flush_load;
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      mode_q       <= MODE_PARITY;
      held_line    <= '0;
      held_par     <= '0;
      prev_par     <= '0;
      write_value  <= '0;
      write_index  <= '0;
      write_enable <= 1'b0;
      cnt_value    <= '0;
      donee        <= 1'b0;
    end else begin
      donee <= 1'b0;

      if (load) begin
        write_enable <= 1'b1;
        if (in_flush) begin
          write_value <= slice_theta;
          write_index <= '0;
        end else begin
          write_value <= (mode_q == MODE_THETA) ? slice_theta : par_line;
          write_index <= cnt_value[CW-2:0];
        end
      end else if (drain) begin
        write_enable <= 1'b0;
      end

      if (accept) begin
        prev_par  <= slice_par;
        cnt_value <= cnt_value + 1'b1;
        if (slot0) begin
          held_line <= line_in;
          held_par  <= slice_par;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            mode_q    <= mode;
            cnt_value <= '0;
            state     <= STREAM;
          end
        end
        STREAM: begin
          if (accept && cnt_value == LAST) begin
            state <= (mode_q == MODE_THETA) ? FLUSH : DRAIN;
          end
        end
        FLUSH: begin
          if (flush_load) state <= DRAIN;
        end
        DRAIN: begin
          if (!write_enable || write_ready) begin
            donee <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_col_parity_engine.sv
// Bench for col_parity_engine: a DEPTH=4 instance for directed cases and a
// DEPTH=64 instance for back-to-back random streaming.
module tb_col_parity_engine;

  typedef logic [24:0] line_t;
  typedef line_t       line_q_t[$];
  typedef logic [30:0] exp_t;
  typedef exp_t        exp_q_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        a_start = 0, a_mode = 0, a_valid = 0, a_wready = 1;
  line_t       a_line = '0;
  logic        a_in_ready, a_we, a_donee;
  line_t       a_wv;
  logic [1:0]  a_wi;
  logic [2:0]  a_cnt;
  logic [1:0]  a_state;

  logic        b_start = 0, b_mode = 0, b_valid = 0, b_wready = 1;
  line_t       b_line = '0;
  logic        b_in_ready, b_we, b_donee;
  line_t       b_wv;
  logic [5:0]  b_wi;
  logic [6:0]  b_cnt;
  logic [1:0]  b_state;

  exp_t        exp4_q[$];
  exp_t        exp64_q[$];
  int          last_xfer4 = 0, last_xfer64 = 0;
  logic        a_stall = 0, b_stall = 0;
  line_t       a_hold_v, b_hold_v;
  logic [5:0]  a_hold_i, b_hold_i;

  col_parity_engine #(.ROWS(5), .COLS(5), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(a_start), .mode(a_mode), .line_in(a_line),
    .in_valid(a_valid), .in_ready(a_in_ready), .write_value(a_wv),
    .write_index(a_wi), .write_enable(a_we), .write_ready(a_wready),
    .cnt_value(a_cnt), .donee(a_donee), .state_dbg(a_state)
  );

  col_parity_engine #(.ROWS(5), .COLS(5), .DEPTH(64)) u_dut64 (
    .clk(clk), .rst(rst), .start(b_start), .mode(b_mode), .line_in(b_line),
    .in_valid(b_valid), .in_ready(b_in_ready), .write_value(b_wv),
    .write_index(b_wi), .write_enable(b_we), .write_ready(b_wready),
    .cnt_value(b_cnt), .donee(b_donee), .state_dbg(b_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // reference model
  function automatic logic [4:0] m_par(input line_t l);
    logic [4:0] p;
    p = '0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        p[x] = p[x] ^ l[y*5+x];
    return p;
  endfunction

  function automatic exp_q_t build_expect(input int depth, input logic md, input line_q_t ln);
    exp_q_t     r;
    logic [4:0] c[64];
    line_t      v;
    line_t      cur;
    int         z;
    for (int i = 0; i < depth; i++) c[i] = m_par(ln[i]);
    for (int k = 0; k < depth; k++) begin
      v = '0;
      if (md == 1'b0) begin
        z = k;
        v[4:0] = c[z];
      end else begin
        z = (k + 1) % depth;
        cur = ln[z];
        for (int x = 0; x < 5; x++)
          for (int y = 0; y < 5; y++)
            v[y*5+x] = cur[y*5+x] ^ c[z][(x+4)%5] ^ c[(z+depth-1)%depth][(x+1)%5];
      end
      r.push_back({6'(z), v});
    end
    return r;
  endfunction

  // scoreboard / compare process
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (a_stall) begin
        chk("a_hold_enable", a_we, 1'b1);
        chk("a_hold_value", a_wv, a_hold_v);
        chk("a_hold_index", a_wi, a_hold_i);
      end
      if (a_we && a_wready) begin
        chk("a_output_expected", exp4_q.size() != 0, 1'b1);
        if (exp4_q.size() != 0) begin
          e = exp4_q.pop_front();
          chk("a_value", a_wv, e[24:0]);
          chk("a_index", a_wi, e[30:25]);
        end
        last_xfer4 = cyc;
      end
      a_stall  = a_we && !a_wready;
      a_hold_v = a_wv;
      a_hold_i = 6'(a_wi);

      if (b_stall) begin
        chk("b_hold_value", b_wv, b_hold_v);
        chk("b_hold_index", b_wi, b_hold_i);
      end
      if (b_we && b_wready) begin
        chk("b_output_expected", exp64_q.size() != 0, 1'b1);
        if (exp64_q.size() != 0) begin
          e = exp64_q.pop_front();
          chk("b_value", b_wv, e[24:0]);
          chk("b_index", b_wi, e[30:25]);
        end
        last_xfer64 = cyc;
      end
      b_stall  = b_we && !b_wready;
      b_hold_v = b_wv;
      b_hold_i = b_wi;
    end else begin
      a_stall = 1'b0;
      b_stall = 1'b0;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start4(input logic md);
    a_mode  = md;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic send4(input line_t l);
    int n;
    n = 0;
    a_line  = l;
    a_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (a_in_ready) break;
      n++;
      if (n > 100) begin
        chk("a_send_timeout", a_in_ready, 1'b1);
        break;
      end
    end
    tick();
    a_valid = 1'b0;
  endtask

  task automatic wait_done4();
    int n;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      if (a_donee) break;
      n++;
    end
    chk("a_donee_seen", a_donee, 1'b1);
    chk("a_donee_latency", cyc - last_xfer4, 1);
    chk("a_cnt_final", a_cnt, 4);
    @(negedge clk);
    chk("a_donee_width", a_donee, 1'b0);
    chk("a_cnt_hold", a_cnt, 4);
  endtask

  task automatic check_reset4(input string tag);
    chk({tag, "_in_ready"}, a_in_ready, 1'b0);
    chk({tag, "_write_enable"}, a_we, 1'b0);
    chk({tag, "_donee"}, a_donee, 1'b0);
    chk({tag, "_cnt"}, a_cnt, 0);
    chk({tag, "_value"}, a_wv, 0);
    chk({tag, "_index"}, a_wi, 0);
    chk({tag, "_state"}, a_state, 0);
  endtask

  line_q_t par_lines;
  line_q_t th_lines;
  line_q_t rst_lines;
  line_q_t b_lines;
  exp_q_t  pin;

  initial begin
    par_lines = '{25'h1FFFFFF, 25'h0000000, 25'h0000001, 25'h0000021};
    th_lines  = '{25'h0000001, 25'h0000000, 25'h0000000, 25'h0000000};
    rst_lines = '{25'h0AAAAAA, 25'h1555555, 25'h0F0F0F0, 25'h1234567};

    // hand-computed pins on the model
    pin = build_expect(4, 1'b0, par_lines);
    chk("model_par_0", pin[0], {6'd0, 25'h000001F});
    chk("model_par_1", pin[1], {6'd1, 25'h0000000});
    chk("model_par_2", pin[2], {6'd2, 25'h0000001});
    chk("model_par_3", pin[3], {6'd3, 25'h0000000});
    pin = build_expect(4, 1'b1, th_lines);
    chk("model_theta_1", pin[0], {6'd1, 25'h1084210});
    chk("model_theta_2", pin[1], {6'd2, 25'h0000000});
    chk("model_theta_3", pin[2], {6'd3, 25'h0000000});
    chk("model_theta_0", pin[3], {6'd0, 25'h0210843});

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset4("reset");
    chk("b_reset_in_ready", b_in_ready, 1'b0);
    chk("b_reset_cnt", b_cnt, 0);
    chk("b_reset_write_enable", b_we, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // parity mode
    exp4_q = build_expect(4, 1'b0, par_lines);
    start4(1'b0);
    foreach (par_lines[i]) send4(par_lines[i]);
    wait_done4();

    // theta mode, unstalled
    exp4_q = build_expect(4, 1'b1, th_lines);
    start4(1'b1);
    foreach (th_lines[i]) send4(th_lines[i]);
    wait_done4();

    // theta mode, write_ready low for 5 cycles after the first output
    exp4_q   = build_expect(4, 1'b1, th_lines);
    a_wready = 1'b0;
    start4(1'b1);
    fork
      begin
        foreach (th_lines[i]) send4(th_lines[i]);
      end
      begin
        int n;
        n = 0;
        while (n < 100) begin
          @(negedge clk);
          if (a_we) break;
          n++;
        end
        chk("stall_first_output", a_we, 1'b1);
        repeat (5) begin
          chk("stall_in_ready", a_in_ready, 1'b0);
          @(negedge clk);
        end
        @(posedge clk);
        #1 a_wready = 1'b1;
      end
    join
    wait_done4();

    // reset while streaming, after 2 slices
    exp4_q = build_expect(4, 1'b0, rst_lines);
    start4(1'b0);
    send4(rst_lines[0]);
    send4(rst_lines[1]);
    rst = 1'b0;
    #2;
    check_reset4("abort");
    exp4_q.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("abort_no_donee", a_donee, 1'b0);
    end
    tick();
    exp4_q = build_expect(4, 1'b1, rst_lines);
    start4(1'b1);
    foreach (rst_lines[i]) send4(rst_lines[i]);
    wait_done4();

    // back-to-back theta on DEPTH=64, start pulsed mid-matrix
    for (int i = 0; i < 64; i++) b_lines.push_back(25'($urandom()));
    exp64_q = build_expect(64, 1'b1, b_lines);
    b_mode  = 1'b1;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    b_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      b_line  = b_lines[i];
      b_start = (i == 30);
      b_mode  = 1'b0;
      @(negedge clk);
      chk("b_in_ready", b_in_ready, 1'b1);
      if (i == 31) chk("b_cnt_after_start", b_cnt, 31);
      tick();
    end
    b_valid = 1'b0;
    b_start = 1'b0;
    begin
      int n;
      n = 0;
      while (n < 300) begin
        @(negedge clk);
        if (b_donee) break;
        n++;
      end
      chk("b_donee_seen", b_donee, 1'b1);
      chk("b_donee_latency", cyc - last_xfer64, 1);
      chk("b_cnt_final", b_cnt, 64);
    end

    tick();
    chk("a_queue_empty", exp4_q.size(), 0);
    chk("b_queue_empty", exp64_q.size(), 0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/col_parity_engine.md
# col_parity_engine

Parametrised, streaming column-parity / theta engine for the matrix encoder. It is the next generation of the fixed 5×5×64 column-parity function. It accepts one slice (ROWS×COLS bits) per handshake and runs in one of two modes: parity-only, which emits the column parities per slice, or theta, which emits each slice XORed with its neighbouring column parities and wraps around the slice index. It sits between the line reader and the line writer, and replaces the start/done-only controller with valid/ready flow control on both sides.

## Interface
- ROWS, 5, rows per slice (y)
- COLS, 5, columns per slice (x); must be ≥3
- DEPTH, 64, slices per matrix (z); must be ≥2
- CW, $clog2(DEPTH)+1, counter width

- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- start  in  1  one-cycle pulse in IDLE; begins a matrix
- mode  in  1  0 = parity-only, 1 = theta; sampled on start
- line_in  in  ROWS*COLS  slice data; bit y*COLS+x = A[x][y][z]
- in_valid  in  1  line_in valid
- in_ready  out  1  engine accepts line_in
- write_value  out  ROWS*COLS  result; parity mode uses bits [COLS-1:0], upper bits are 0
- write_index  out  CW-1  slice index z of write_value
- write_enable  out  1  output valid
- write_ready  in  1  downstream accepts output
- cnt_value  out  CW  slices accepted so far in the current matrix
- donee  out  1  one-cycle pulse when the matrix is complete

## Operation
- Column parity: C[x][z] = XOR over y of A[x][y][z].
- Theta result: A'[x][y][z] = A[x][y][z] ^ C[(x-1) mod COLS][z] ^ C[(x+1) mod COLS][(z-1) mod DEPTH].
- States:
  - IDLE: start → STREAM; clears cnt_value; latches mode.
  - STREAM: accepts DEPTH slices, then goes to FLUSH (theta) or DRAIN (parity).
  - FLUSH: emits held slice 0 → DRAIN.
  - DRAIN: waits for the output register to empty, pulses donee → IDLE.
- Parity mode: slice z produces write_value = {0, C[COLS-1:0][z]} with write_index = z, in input order.
- Theta mode:
  - Slice 0 line and C[·][0] are held in internal registers; nothing is emitted for slice 0 on acceptance.
  - Slice z ≥ 1 is emitted on acceptance, using a prev-parity register holding C[·][z-1].
  - After slice DEPTH-1 is accepted, FLUSH emits slice 0 using C[·][DEPTH-1].
  - Output order is 1..DEPTH-1, then 0.
- Storage: one output register, one held-line register, two COLS-bit parity registers. No RAM.
- start outside IDLE is ignored. in_valid outside STREAM is ignored, and in_ready = 0 there.

## Timing
- Reset (rst low, async): state = IDLE.
  - Outputs: in_ready = 0, write_enable = 0, donee = 0, cnt_value = 0, write_value = 0, write_index = 0.
  - All internal registers cleared.
- Reset mid-matrix aborts immediately. The partial matrix is discarded and no donee is issued.
- Handshake:
  - A transfer occurs on a rising edge where valid && ready.
  - write_enable, once high, holds write_value and write_index stable until write_ready.
- in_ready = STREAM && (output register empty || write_ready). In theta mode, slice 0 does not need the output register, so in STREAM with cnt_value = 0, in_ready = 1.
- Latency: the output register is valid one cycle after the accepting edge. Sustained throughput is 1 slice/cycle when write_ready is held high.
- FLUSH loads slice 0 into the output register on the first cycle it is empty or being drained. It then waits for that transfer.
- donee rises the cycle after the final output transfer, for exactly one cycle. cnt_value stays at DEPTH until the next start.
- Simultaneous input accept and output drain in the same cycle: both occur, and no bubble is inserted.

## Structure
- Shared package col_parity_pkg:
  - state enum {IDLE, STREAM, FLUSH, DRAIN}
  - mode constants MODE_PARITY = 0, MODE_THETA = 1
  - function col_parity(line) → COLS bits
- Sub-module col_parity_slice: combinational ROWS×COLS → COLS XOR tree plus theta mixing, parametrised by ROWS and COLS.
- Top: controller FSM, counter, and registers.

## Test plan
- ROWS=5, COLS=5, DEPTH=4, parity mode, lines 0x1FFFFFF, 0, 0x0000001, 0x0000021:
  - Outputs 0x1F, 0x00, 0x01, 0x00 with indices 0..3.
  - donee one cycle after the last transfer; cnt_value = 4.
- Theta mode, DEPTH=4, slice 0 = 0x0000001, other slices 0:
  - Emission order: z=1 → 0x1084210, z=2 → 0, z=3 → 0, then z=0 → 0x0210843.
- Theta mode, write_ready held low for 5 cycles after the first output:
  - write_value and write_index stay stable throughout; in_ready = 0.
  - No data is lost; results match the unstalled run.
- Reset asserted while in STREAM after 2 slices:
  - All outputs go to their reset values asynchronously; no donee.
  - A new start then completes a correct matrix.
- Back-to-back: in_valid and write_ready held high, DEPTH=64, random data, theta mode:
  - 1 slice accepted per cycle; all 64 outputs match the reference model.
  - start pulsed mid-matrix has no effect.
